rom_stream_reader: RTL and testbench

Initiator-side bridge between an AXI-Stream of lookup addresses and the single-cycle `en`/`addr`/`data`/`ack` ROM port used by the KAN lookup tables. It accepts addresses on a slave stream, issues ROM reads, and buffers the returned words with their `tlast` marker. It presents the words on a master stream with full backpressure support. It uses credit-based flow control, so no ROM response is ever dropped. One instance drives one ROM channel.

---
 rtl/rom_stream_reader_pkg.sv | 9 +
 rtl/rom_stream_reader_axis_fifo_sync.sv | 56 +++++
 rtl/rom_stream_reader.sv | 111 +++++++++++
 tb/tb_rom_stream_reader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared helpers for the ROM stream reader slice: pointer sizing for the
// power-of-two FIFOs and the credit counter.
package rom_stream_reader_pkg;

  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rom_stream_reader_axis_fifo_sync.sv
// Synchronous FIFO with async active-high reset. Pointers carry one extra
// wrap bit so full and empty are distinguishable. DEPTH must be a power of two.
module axis_fifo_sync
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = ptr_bits(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is not reset; visibility is governed entirely by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/rom_stream_reader.sv
// AXI-Stream address-in / data-out bridge to a single-cycle en/addr/data/ack
// ROM port, with credit-based flow control so no ROM response is dropped.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  rom_ack,
  output logic                  err
);

  localparam int unsigned CW = ptr_bits(DEPTH) + 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                issue;
  logic                out_hs;

  logic                tag_head;
  logic                tag_full;
  logic                tag_empty;
  logic                tag_pop;

  logic [DATA_WIDTH:0] rsp_head;
  logic                rsp_full;
  logic                rsp_empty;
  logic                rsp_push;
  logic                ack_bad;

  // Credits cover in-flight reads plus buffered words, so the tag queue can
  // never be full while a credit remains; the tag_full term is redundant.
  assign s_axis_tready = !rst && (cnt_q < CW'(DEPTH)) && !tag_full;
  assign issue         = s_axis_tvalid && s_axis_tready;

  assign rom_en        = issue;
  assign rom_addr      = issue ? s_axis_tdata : '0;

  assign m_axis_tvalid = !rsp_empty;
  assign m_axis_tdata  = rsp_empty ? '0 : rsp_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !rsp_empty && rsp_head[DATA_WIDTH];
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  assign ack_bad       = rom_ack && (tag_empty || rsp_full);
  assign rsp_push      = rom_ack && !ack_bad;
  assign tag_pop       = rsp_push;
  assign err           = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | ack_bad;
    unique case ({issue, out_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  axis_fifo_sync #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (issue),
    .data_i  (s_axis_tlast),
    .pop_i   (tag_pop),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  axis_fifo_sync #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_rsp_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rsp_push),
    .data_i  ({tag_head, rom_data}),
    .pop_i   (out_hs),
    .head_o  (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: behavioural 1-cycle ROM plus an expected-word
// queue filled from accepted addresses and the ROM contents.
module tb_rom_stream_reader;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_axis_tready;
  logic       s_tlast;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_ready;
  logic       m_axis_tlast;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       rom_ack;
  logic       err;

  logic       rom_ack_q = 1'b0;
  logic [7:0] rom_data_q = '0;
  logic       spur;
  logic [7:0] rom_mem [256];
  logic [8:0] exp_q [$];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rom_stream_reader #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_axis_tlast),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rom_ack       (rom_ack),
    .err           (err)
  );

  always @(posedge clk) begin
    rom_ack_q  <= rom_en;
    rom_data_q <= rom_mem[rom_addr];
  end
  assign rom_ack  = rom_ack_q | spur;
  assign rom_data = rom_data_q;

  // Drive one cycle of inputs; outputs are valid for sampling on return.
  task automatic tick(input logic v, input logic [7:0] a, input logic l,
                      input logic r, input logic sp);
    @(negedge clk);
    s_tvalid = v; s_tdata = a; s_tlast = l; m_ready = r; spur = sp;
    #1;
    if (v && s_axis_tready) exp_q.push_back({l, rom_mem[a]});
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h11; s_tlast = 1'b0;
    m_ready = 1'b1; spur = 1'b0;
    #1;
    compared++;
    if ({s_axis_tready, rom_en, m_axis_tvalid, err} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_outputs: got tready,en,tvalid,err=%b required 0000",
               {s_axis_tready, rom_en, m_axis_tvalid, err});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; s_tvalid = 1'b0;
    #1;
    compared++;
    if (s_axis_tready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_tready: got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_single;
    logic [8:0] e;
    tick(1'b1, 8'h05, 1'b1, 1'b1, 1'b0);
    compared++;
    if ({rom_en, rom_addr} !== {1'b1, 8'h05}) begin
      mismatched++;
      $display("FAIL single_issue: got en=%b addr=%h required en=1 addr=05", rom_en, rom_addr);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++;
    if (m_axis_tvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_early: got tvalid=%b in cycle 1 required 0", m_axis_tvalid);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    compared++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, 1'b1, 8'hA7}) begin
      mismatched++;
      $display("FAIL single_word: got v=%b l=%b d=%h required v=1 l=1 d=a7",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_streaming;
    int first = -1;
    int lastc = -1;
    int n = 0;
    logic [8:0] e;
    for (int i = 0; i < 30; i++) begin
      if (i < 16) tick(1'b1, 8'(i), (i == 15), 1'b1, 1'b0);
      else        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (i < 16) begin
        compared++;
        if (s_axis_tready !== 1'b1) begin
          mismatched++;
          $display("FAIL stream_tready: cycle %0d got %b required 1", i, s_axis_tready);
        end
      end
      if (m_axis_tvalid) begin
        if (n == 0) first = i;
        n++;
        lastc = i;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL stream_extra: got %h required no word", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            mismatched++;
            $display("FAIL stream_word: got %h required %h", {m_axis_tlast, m_axis_tdata}, e);
          end
        end
      end
    end
    compared++;
    if (first != 2 || n != 16 || lastc - first != 15) begin
      mismatched++;
      $display("FAIL stream_timing: got first=%0d count=%0d span=%0d required 2/16/15",
               first, n, lastc - first);
    end
  endtask

  task automatic test_backpressure;
    int k = 0;
    int acc = 0;
    int got = 0;
    logic [8:0] held;
    logic [8:0] e;
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 8'h40 + 8'(k), (k == 7), 1'b0, 1'b0);
      if (s_axis_tready) begin acc++; k++; end
    end
    compared++;
    if (acc != DEPTH) begin
      mismatched++;
      $display("FAIL bp_accepted: got %0d required %0d", acc, DEPTH);
    end
    tick(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0, 1'b0);
    held = {m_axis_tlast, m_axis_tdata};
    compared++;
    if ({s_axis_tready, m_axis_tvalid} !== 2'b01) begin
      mismatched++;
      $display("FAIL bp_stalled: got tready=%b tvalid=%b required 0 1", s_axis_tready, m_axis_tvalid);
    end
    tick(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0, 1'b0);
    compared++;
    if ({m_axis_tlast, m_axis_tdata} !== held) begin
      mismatched++;
      $display("FAIL bp_hold: got %h required %h", {m_axis_tlast, m_axis_tdata}, held);
    end
    for (int c = 0; c < 40 && got < 8; c++) begin
      tick(k < 8, 8'h40 + 8'(k), (k == 7), 1'b1, 1'b0);
      if (c == 1) begin
        compared++;
        if (s_axis_tready !== 1'b1) begin
          mismatched++;
          $display("FAIL bp_credit_return: got tready=%b required 1", s_axis_tready);
        end
      end
      if (k < 8 && s_axis_tready) k++;
      if (m_axis_tvalid) begin
        got++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL bp_extra: got %h required no word", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            mismatched++;
            $display("FAIL bp_word: got %h required %h", {m_axis_tlast, m_axis_tdata}, e);
          end
        end
      end
    end
    compared++;
    if (got != 8) begin
      mismatched++;
      $display("FAIL bp_count: got %0d words required 8", got);
    end
  endtask

  task automatic test_spurious_ack;
    int acc = 0;
    int got = 0;
    logic [8:0] e;
    for (int c = 0; c < 4; c++) tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      compared++;
      if ({err, m_axis_tvalid} !== 2'b10) begin
        mismatched++;
        $display("FAIL spur_err: got err=%b tvalid=%b required 1 0", err, m_axis_tvalid);
      end
    end
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 8'h80 + 8'(acc), (acc == 3), 1'b0, 1'b0);
      if (s_axis_tready) acc++;
    end
    compared++;
    if (acc != DEPTH) begin
      mismatched++;
      $display("FAIL spur_credits: got %0d accepted required %0d", acc, DEPTH);
    end
    for (int c = 0; c < 20 && got < DEPTH; c++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (m_axis_tvalid) begin
        got++;
        compared++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
        if ({m_axis_tlast, m_axis_tdata} !== e) begin
          mismatched++;
          $display("FAIL spur_word: got %h required %h", {m_axis_tlast, m_axis_tdata}, e);
        end
      end
    end
    compared++;
    if (got != DEPTH || err !== 1'b1) begin
      mismatched++;
      $display("FAIL spur_drain: got words=%0d err=%b required %0d 1", got, err, DEPTH);
    end
  endtask

  task automatic test_reset_mid;
    int acc = 0;
    int got = 0;
    logic [8:0] e;
    tick(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h23; m_ready = 1'b1;
    #1;
    exp_q.delete();
    compared++;
    if ({s_axis_tready, rom_en, rom_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata, err}
        !== 21'd0) begin
      mismatched++;
      $display("FAIL rstmid_outputs: got rdy=%b en=%b a=%h v=%b l=%b d=%h err=%b required all 0",
               s_axis_tready, rom_en, rom_addr, m_axis_tvalid, m_axis_tlast, m_axis_tdata, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; s_tvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      compared++;
      if ({s_axis_tready, m_axis_tvalid, err} !== 3'b100) begin
        mismatched++;
        $display("FAIL rstmid_after: got rdy=%b v=%b err=%b required 1 0 0",
                 s_axis_tready, m_axis_tvalid, err);
      end
    end
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 8'hC0 + 8'(acc), 1'b0, 1'b0, 1'b0);
      if (s_axis_tready) acc++;
    end
    compared++;
    if (acc != DEPTH) begin
      mismatched++;
      $display("FAIL rstmid_credits: got %0d accepted required %0d", acc, DEPTH);
    end
    for (int c = 0; c < 20 && got < DEPTH; c++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (m_axis_tvalid) begin
        got++;
        compared++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1ff;
        if ({m_axis_tlast, m_axis_tdata} !== e) begin
          mismatched++;
          $display("FAIL rstmid_word: got %h required %h", {m_axis_tlast, m_axis_tdata}, e);
        end
      end
    end
  endtask

  task automatic test_random;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic       v = 1'b0;
    logic [7:0] a = '0;
    logic       l = 1'b0;
    logic       r;
    logic       stall_prev = 1'b0;
    logic [8:0] held = '0;
    logic [8:0] e;
    while ((got < 1000) && (cyc < 20000)) begin
      if (!v && sent < 1000 && $urandom_range(0, 9) < 7) begin
        v = 1'b1;
        a = 8'($urandom);
        l = ($urandom_range(0, 3) == 0) || (sent == 999);
      end
      r = 1'($urandom);
      tick(v, a, l, r, 1'b0);
      cyc++;
      if (stall_prev) begin
        compared++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, held}) begin
          mismatched++;
          $display("FAIL rand_stable: got v=%b %h required v=1 %h",
                   m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, held);
        end
      end
      stall_prev = m_axis_tvalid && !r;
      held = {m_axis_tlast, m_axis_tdata};
      if (v && s_axis_tready) begin v = 1'b0; sent++; end
      if (m_axis_tvalid && r) begin
        got++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rand_extra: got %h required no word", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            mismatched++;
            $display("FAIL rand_word: got %h required %h", {m_axis_tlast, m_axis_tdata}, e);
          end
        end
      end
    end
    compared++;
    if (got != 1000 || sent != 1000 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL rand_total: got words=%0d sent=%0d err=%b required 1000 1000 0",
               got, sent, err);
    end
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    m_ready = 1'b0; spur = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    rom_mem[8'h05] = 8'hA7;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_spurious_ack();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
